// File: rtl/ic_pkg.sv
// Shared definitions for the priority interrupt controller: FSM state
// encodings, register offsets and STATUS field layout.
package ic_pkg;

  // One-hot controller states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b001,
    ST_ARB      = 3'b010,
    ST_WAIT_SVC = 3'b100
  } ic_state_e;

  // Width of the vector index presented to the processor.
  localparam int VEC_W = 5;

  // Register byte offsets. Addresses are zero-extended to 32 bits before decode.
  localparam logic [31:0] ADDR_PRIO_BASE    = 32'h00;
  localparam logic [31:0] ADDR_PRIO_LAST    = 32'h1F;
  localparam logic [31:0] ADDR_ENABLE_BASE  = 32'h20;
  localparam logic [31:0] ADDR_MODE_BASE    = 32'h24;
  localparam logic [31:0] ADDR_THRESH       = 32'h28;
  localparam logic [31:0] ADDR_STATUS       = 32'h29;
  localparam logic [31:0] ADDR_PENDING_BASE = 32'h2C;

  // STATUS layout: {valid, 2'b00, vector[4:0]}.
  localparam int STATUS_VALID_BIT = 7;
  localparam int STATUS_VEC_LSB   = 0;

  // Pick one byte lane out of a 32-bit line-indexed register image.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Assemble the STATUS byte from the presented vector state.
  function automatic logic [7:0] status_byte(input logic valid, input logic [VEC_W-1:0] vec);
    logic [7:0] s;
    s = '0;
    s[STATUS_VALID_BIT] = valid;
    s[STATUS_VEC_LSB +: VEC_W] = vec;
    return s;
  endfunction

endpackage

// File: rtl/ic_prio_arbiter.sv
// Combinational winner select: highest PRIO among eligible lines, ties
// resolved towards the lowest line index.
module ic_prio_arbiter
  import ic_pkg::*;
#(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4
) (
  input  logic [NUM_INTR-1:0]        eligible_i,
  input  logic [NUM_INTR*PRIO_W-1:0] prio_i,
  output logic                       any_o,
  output logic [VEC_W-1:0]           idx_o
);

  logic              any_w;
  logic [VEC_W-1:0]  idx_w;
  logic [PRIO_W-1:0] best_w;

  // Scan from index 0 upward; only a strictly larger PRIO displaces the
  // current best, which is what makes the lowest index win a tie.
  always_comb begin
    any_w  = 1'b0;
    idx_w  = '0;
    best_w = '0;
    for (int k = 0; k < NUM_INTR; k++) begin
      if (eligible_i[k] && (!any_w || (prio_i[k*PRIO_W +: PRIO_W] > best_w))) begin
        any_w  = 1'b1;
        idx_w  = VEC_W'(k);
        best_w = prio_i[k*PRIO_W +: PRIO_W];
      end
    end
  end

  assign any_o = any_w;
  assign idx_o = idx_w;

endmodule

// File: rtl/ic_prio_ctrl.sv
// Priority interrupt controller: register file behind a two-cycle bus
// handshake, level/edge pending tracking, and a three-state vector FSM.
module ic_prio_ctrl
  import ic_pkg::*;
#(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic                pclk_i,
  input  logic                prst_n_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic                pwrite_i,
  input  logic                penable_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                perror_o,
  output logic                intr_valid_o,
  output logic [VEC_W-1:0]    intr_to_service_o,
  input  logic                intr_serviced_i,
  input  logic [NUM_INTR-1:0] intr_active_i
);

  // Configuration registers
  logic [NUM_INTR*PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_INTR-1:0]        enable_q, enable_d;
  logic [NUM_INTR-1:0]        mode_q, mode_d;
  logic [PRIO_W-1:0]          thresh_q, thresh_d;

  // Pending tracking
  logic [NUM_INTR-1:0] line_q, line_d;
  logic [NUM_INTR-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_INTR-1:0] rise;
  logic [NUM_INTR-1:0] svc_clr;
  logic [NUM_INTR-1:0] pending;
  logic [NUM_INTR-1:0] eligible;

  // FSM
  ic_state_e        state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             win_any;
  logic [VEC_W-1:0] win_idx;

  // Bus
  logic              pready_q, pready_d;
  logic              perror_q, perror_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              access;
  logic              dec_err;
  logic [DATA_W-1:0] rd_data;
  logic [31:0]       addr_ext;
  logic [31:0]       enable_ext;
  logic [31:0]       mode_ext;
  logic [31:0]       pending_ext;

  // ---------------------------------------------------------------------
  // Pending and eligibility
  // ---------------------------------------------------------------------

  // Level lines follow the live input; edge lines use the sticky flag.
  // A line counts as eligible only when enabled and strictly above THRESH.
  for (genvar gi = 0; gi < NUM_INTR; gi++) begin : g_line
    assign rise[gi]     = intr_active_i[gi] & ~line_q[gi];
    assign svc_clr[gi]  = (state_q == ST_WAIT_SVC) & intr_serviced_i & (vec_q == VEC_W'(gi));
    assign pending[gi]  = mode_q[gi] ? edge_pend_q[gi] : intr_active_i[gi];
    assign eligible[gi] = pending[gi] & enable_q[gi] &
                          (prio_q[gi*PRIO_W +: PRIO_W] > thresh_q);
  end

  // Edge flags: a fresh rising edge wins over a service clear in the same cycle.
  always_comb begin
    line_d      = intr_active_i;
    edge_pend_d = ((edge_pend_q & ~svc_clr) | rise) & mode_q;
  end

  // Register the sampled lines and the edge-pending flags.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      line_q      <= '0;
      edge_pend_q <= '0;
    end else begin
      line_q      <= line_d;
      edge_pend_q <= edge_pend_d;
    end
  end

  ic_prio_arbiter #(
    .NUM_INTR (NUM_INTR),
    .PRIO_W   (PRIO_W)
  ) u_arbiter (
    .eligible_i (eligible),
    .prio_i     (prio_q),
    .any_o      (win_any),
    .idx_o      (win_idx)
  );

  // ---------------------------------------------------------------------
  // Vector FSM
  // ---------------------------------------------------------------------

  // Next state: the winner is captured in ARB and frozen through WAIT_SVC
  // so later line drops or register rewrites cannot disturb the vector.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_any) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_any) begin
          vec_d   = win_idx;
          state_d = ST_WAIT_SVC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_SVC: begin
        if (intr_serviced_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured vector registers.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  assign intr_valid_o      = (state_q == ST_WAIT_SVC);
  assign intr_to_service_o = intr_valid_o ? vec_q : '0;

  // ---------------------------------------------------------------------
  // Register access
  // ---------------------------------------------------------------------

  // An access is taken only when the previous one is not still completing,
  // so a held penable_i cannot be counted twice.
  assign access = penable_i & ~pready_q;

  // Zero-extended images so every byte-sliced register reads 0 beyond NUM_INTR.
  always_comb begin
    addr_ext    = '0;
    enable_ext  = '0;
    mode_ext    = '0;
    pending_ext = '0;
    addr_ext[ADDR_W-1:0]      = paddr_i;
    enable_ext[NUM_INTR-1:0]  = enable_q;
    mode_ext[NUM_INTR-1:0]    = mode_q;
    pending_ext[NUM_INTR-1:0] = pending;
  end

  // Address decode: read data and error flag for the current request.
  always_comb begin
    dec_err = 1'b0;
    rd_data = '0;
    if (addr_ext <= ADDR_PRIO_LAST) begin
      if (addr_ext < 32'(NUM_INTR)) begin
        for (int k = 0; k < NUM_INTR; k++) begin
          if (addr_ext == ADDR_PRIO_BASE + 32'(k)) rd_data[PRIO_W-1:0] = prio_q[k*PRIO_W +: PRIO_W];
        end
      end else begin
        dec_err = 1'b1;
      end
    end else if (addr_ext[31:2] == ADDR_ENABLE_BASE[31:2]) begin
      rd_data = byte_lane(enable_ext, addr_ext[1:0]);
    end else if (addr_ext[31:2] == ADDR_MODE_BASE[31:2]) begin
      rd_data = byte_lane(mode_ext, addr_ext[1:0]);
    end else if (addr_ext == ADDR_THRESH) begin
      rd_data[PRIO_W-1:0] = thresh_q;
    end else if (addr_ext == ADDR_STATUS) begin
      if (pwrite_i) dec_err = 1'b1;
      else          rd_data = status_byte(intr_valid_o, intr_to_service_o);
    end else if (addr_ext[31:2] == ADDR_PENDING_BASE[31:2]) begin
      if (pwrite_i) dec_err = 1'b1;
      else          rd_data = byte_lane(pending_ext, addr_ext[1:0]);
    end else begin
      dec_err = 1'b1;
    end
  end

  // Register writes commit on the accepting edge; errored accesses change nothing.
  always_comb begin
    prio_d   = prio_q;
    enable_d = enable_q;
    mode_d   = mode_q;
    thresh_d = thresh_q;
    if (access && pwrite_i && !dec_err) begin
      for (int k = 0; k < NUM_INTR; k++) begin
        if (addr_ext == ADDR_PRIO_BASE + 32'(k)) prio_d[k*PRIO_W +: PRIO_W] = pwdata_i[PRIO_W-1:0];
        if (addr_ext == ADDR_ENABLE_BASE + 32'(k / 8)) enable_d[k] = pwdata_i[k % 8];
        if (addr_ext == ADDR_MODE_BASE + 32'(k / 8))   mode_d[k]   = pwdata_i[k % 8];
      end
      if (addr_ext == ADDR_THRESH) thresh_d = pwdata_i[PRIO_W-1:0];
    end
  end

  // Configuration register storage.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      prio_q   <= '0;
      enable_q <= '1;
      mode_q   <= '0;
      thresh_q <= '0;
    end else begin
      prio_q   <= prio_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
    end
  end

  // Completion response: one-cycle pready, data zeroed on error or idle.
  always_comb begin
    pready_d = access;
    perror_d = access & dec_err;
    prdata_d = (access && !dec_err && !pwrite_i) ? rd_data : '0;
  end

  // Bus response registers.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      pready_q <= 1'b0;
      perror_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= pready_d;
      perror_q <= perror_d;
      prdata_q <= prdata_d;
    end
  end

  assign pready_o = pready_q;
  assign perror_o = perror_q;
  assign prdata_o = prdata_q;

endmodule

// File: tb/tb_ic_prio_ctrl.sv
// Directed bench for ic_prio_ctrl: register access, arbitration order,
// threshold, enable, edge mode, error responses and reset.
module tb_ic_prio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  paddr = '0;
  logic [7:0]  pwdata = '0;
  logic        pwrite = 1'b0;
  logic        penable = 1'b0;
  logic [7:0]  prdata_o;
  logic        pready_o;
  logic        perror_o;
  logic        intr_valid_o;
  logic [4:0]  intr_to_service_o;
  logic        intr_serviced = 1'b0;
  logic [15:0] intr_active = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ic_prio_ctrl #(
    .NUM_INTR (16),
    .PRIO_W   (4),
    .ADDR_W   (8),
    .DATA_W   (8)
  ) dut (
    .pclk_i            (clk),
    .prst_n_i          (rst_n),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .pwrite_i          (pwrite),
    .penable_i         (penable),
    .prdata_o          (prdata_o),
    .pready_o          (pready_o),
    .perror_o          (perror_o),
    .intr_valid_o      (intr_valid_o),
    .intr_to_service_o (intr_to_service_o),
    .intr_serviced_i   (intr_serviced),
    .intr_active_i     (intr_active)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus access; returns once pready_o has been seen (bounded).
  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic w,
                     output logic [7:0] rd, output logic er);
    int n;
    n = 0;
    paddr = a; pwdata = d; pwrite = w; penable = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!pready_o && n < 8);
    rd = prdata_o;
    er = perror_o;
    if (!pready_o) begin
      chk_cnt++;
      $display("FAIL bus_timeout addr=%02h: no pready_o after %0d cycles", a, n);
    end
    penable = 1'b0;
    pwrite  = 1'b0;
    $display("bus %s addr=%02h wdata=%02h rdata=%02h err=%0b", w ? "WR" : "RD", a, d, rd, er);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic er;
    bus(a, d, 1'b1, rd, er);
  endtask

  task automatic wait_valid(input int max_cyc, output logic seen);
    for (int i = 0; i < max_cyc; i++) begin
      if (intr_valid_o) break;
      @(posedge clk);
      #1;
    end
    seen = intr_valid_o;
    $display("vector valid=%0b idx=%0d", intr_valid_o, intr_to_service_o);
  endtask

  // Pulse intr_serviced for one edge and set the lines for that same edge.
  task automatic svc(input logic [15:0] lines);
    intr_serviced = 1'b1;
    intr_active   = lines;
    @(posedge clk);
    #1;
    intr_serviced = 1'b0;
    $display("service lines_after=%04h", lines);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic e;
    logic s;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk_cnt++;
    if ({intr_valid_o, intr_to_service_o, pready_o, perror_o, prdata_o} !== 16'h0000)
      $display("FAIL reset_outputs: got %04h required 0000",
               {intr_valid_o, intr_to_service_o, pready_o, perror_o, prdata_o});
    else pass_cnt++;
    bus(8'h20, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h0FF) $display("FAIL reset_enable0: got %03h required 0ff", {e, d}); else pass_cnt++;
    bus(8'h22, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL reset_enable2: got %03h required 000", {e, d}); else pass_cnt++;
    bus(8'h24, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL reset_mode0: got %03h required 000", {e, d}); else pass_cnt++;
    bus(8'h28, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL reset_thresh: got %03h required 000", {e, d}); else pass_cnt++;
    // Reset while a vector is being presented.
    wr(8'h00, 8'h01);
    intr_active = 16'h0001;
    wait_valid(8, s);
    chk_cnt++;
    if ({s, intr_to_service_o} !== {1'b1, 5'd0}) $display("FAIL pre_reset_vec: got %b/%0d required 1/0", s, intr_to_service_o);
    else pass_cnt++;
    rst_n = 1'b0;
    #2;
    chk_cnt++;
    if ({intr_valid_o, pready_o} !== 2'b00) $display("FAIL async_reset: valid/pready got %b required 00", {intr_valid_o, pready_o});
    else pass_cnt++;
    step(2);
    intr_active = '0;
    rst_n = 1'b1;
    step(1);
    bus(8'h20, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h0FF) $display("FAIL post_reset_enable: got %03h required 0ff", {e, d}); else pass_cnt++;
    bus(8'h00, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL post_reset_prio0: got %03h required 000", {e, d}); else pass_cnt++;
    bus(8'h29, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL post_reset_status: got %03h required 000", {e, d}); else pass_cnt++;
  endtask

  task automatic test_level_order();
    logic s;
    for (int k = 0; k < 16; k++) wr(8'(k), 8'(k));
    intr_active = 16'h1208;  // lines 3, 9, 12
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd12}) $display("FAIL order_first: got %b/%0d required 1/12", s, intr_to_service_o); else pass_cnt++;
    wr(8'h0C, 8'h00);  // rewrite PRIO[12] while presented
    step(3);
    chk_cnt++; if ({intr_valid_o, intr_to_service_o} !== {1'b1, 5'd12}) $display("FAIL order_hold: got %b/%0d required 1/12", intr_valid_o, intr_to_service_o); else pass_cnt++;
    svc(16'h0208);
    chk_cnt++; if (intr_valid_o !== 1'b0) $display("FAIL order_svc_drop: valid got %b required 0", intr_valid_o); else pass_cnt++;
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd9}) $display("FAIL order_second: got %b/%0d required 1/9", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0008);
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd3}) $display("FAIL order_third: got %b/%0d required 1/3", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0000);
    step(6);
    chk_cnt++; if (intr_valid_o !== 1'b0) $display("FAIL order_idle: valid got %b required 0", intr_valid_o); else pass_cnt++;
  endtask

  task automatic test_tie();
    logic s;
    for (int k = 0; k < 16; k++) wr(8'(k), 8'h05);
    intr_active = 16'h0084;  // lines 2, 7
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd2}) $display("FAIL tie_first: got %b/%0d required 1/2", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0080);
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd7}) $display("FAIL tie_second: got %b/%0d required 1/7", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0000);
  endtask

  task automatic test_thresh();
    logic [7:0] d;
    logic e;
    logic s;
    wr(8'h28, 8'h06);
    wr(8'h04, 8'h06);
    wr(8'h05, 8'h07);
    intr_active = 16'h0030;  // lines 4, 5
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd5}) $display("FAIL thresh_winner: got %b/%0d required 1/5", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0010);
    step(10);
    chk_cnt++; if (intr_valid_o !== 1'b0) $display("FAIL thresh_block: valid got %b required 0", intr_valid_o); else pass_cnt++;
    bus(8'h2C, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h010) $display("FAIL thresh_pending: got %03h required 010", {e, d}); else pass_cnt++;
    intr_active = '0;
    wr(8'h28, 8'h00);
  endtask

  task automatic test_enable();
    logic [7:0] d;
    logic e;
    logic s;
    wr(8'h20, 8'hF7);  // disable line 3
    intr_active = 16'h0008;
    step(8);
    chk_cnt++; if (intr_valid_o !== 1'b0) $display("FAIL enable_mask: valid got %b required 0", intr_valid_o); else pass_cnt++;
    bus(8'h2C, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h008) $display("FAIL enable_pending: got %03h required 008", {e, d}); else pass_cnt++;
    wr(8'h20, 8'hFF);
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd3}) $display("FAIL enable_release: got %b/%0d required 1/3", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0000);
  endtask

  task automatic test_edge();
    logic [7:0] d;
    logic e;
    logic s;
    wr(8'h01, 8'h03);
    wr(8'h24, 8'h02);  // line 1 edge mode
    bus(8'h24, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h002) $display("FAIL edge_mode_rb: got %03h required 002", {e, d}); else pass_cnt++;
    intr_active = 16'h0002;
    step(2);
    intr_active = '0;
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd1}) $display("FAIL edge_vec: got %b/%0d required 1/1", s, intr_to_service_o); else pass_cnt++;
    bus(8'h2C, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h002) $display("FAIL edge_pending_held: got %03h required 002", {e, d}); else pass_cnt++;
    bus(8'h29, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h081) $display("FAIL edge_status: got %03h required 081", {e, d}); else pass_cnt++;
    svc(16'h0000);
    bus(8'h2C, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL edge_pending_clr: got %03h required 000", {e, d}); else pass_cnt++;
    chk_cnt++; if (intr_valid_o !== 1'b0) $display("FAIL edge_idle: valid got %b required 0", intr_valid_o); else pass_cnt++;
    // New pulse coinciding with service re-pends the line.
    intr_active = 16'h0002;
    step(2);
    intr_active = '0;
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd1}) $display("FAIL edge_vec2: got %b/%0d required 1/1", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0002);
    intr_active = '0;
    bus(8'h2C, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h002) $display("FAIL edge_set_wins: got %03h required 002", {e, d}); else pass_cnt++;
    wait_valid(8, s);
    chk_cnt++; if ({s, intr_to_service_o} !== {1'b1, 5'd1}) $display("FAIL edge_reissue: got %b/%0d required 1/1", s, intr_to_service_o); else pass_cnt++;
    svc(16'h0000);
    bus(8'h2C, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL edge_final_clr: got %03h required 000", {e, d}); else pass_cnt++;
    wr(8'h24, 8'h00);
  endtask

  task automatic test_errors();
    logic [7:0] d;
    logic e;
    int pulses;
    bus(8'h30, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h100) $display("FAIL err_unmapped: got %03h required 100", {e, d}); else pass_cnt++;
    bus(8'h29, 8'hFF, 1'b1, d, e);
    chk_cnt++; if ({e, d} !== 9'h100) $display("FAIL err_status_wr: got %03h required 100", {e, d}); else pass_cnt++;
    bus(8'h14, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h100) $display("FAIL err_prio20: got %03h required 100", {e, d}); else pass_cnt++;
    bus(8'h2C, 8'hFF, 1'b1, d, e);
    chk_cnt++; if ({e, d} !== 9'h100) $display("FAIL err_pending_wr: got %03h required 100", {e, d}); else pass_cnt++;
    bus(8'h2A, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h100) $display("FAIL err_gap: got %03h required 100", {e, d}); else pass_cnt++;
    bus(8'h29, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL err_status_kept: got %03h required 000", {e, d}); else pass_cnt++;
    bus(8'h0F, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h005) $display("FAIL err_prio15_ok: got %03h required 005", {e, d}); else pass_cnt++;
    bus(8'h2F, 8'h00, 1'b0, d, e);
    chk_cnt++; if ({e, d} !== 9'h000) $display("FAIL err_pending3_ok: got %03h required 000", {e, d}); else pass_cnt++;
    step(1);
    // Held request: four cycles must produce exactly two completions.
    paddr = 8'h28; pwrite = 1'b0; penable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (pready_o) pulses++;
    end
    penable = 1'b0;
    $display("held request pready pulses=%0d", pulses);
    chk_cnt++; if (pulses !== 2) $display("FAIL held_penable: pulses got %0d required 2", pulses); else pass_cnt++;
    step(2);
  endtask

  initial begin
    test_reset();
    test_level_order();
    test_tie();
    test_thresh();
    test_enable();
    test_edge();
    test_errors();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
